// File: rtl/reg_file.sv
// RV32I integer register file: 32 x 32-bit, two combinational read ports,
// one synchronous write port, x0 hardwired to zero.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high clear of all registers
//   RegWrite    write enable
//   Rs1, Rs2    read indices
//   Rd          write index
//   Write_data  write data
//   read_data1  regs[Rs1], zero when Rs1 == 0
//   read_data2  regs[Rs2], zero when Rs2 == 0

module reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite,
  input  logic [4:0]  Rs1,
  input  logic [4:0]  Rs2,
  input  logic [4:0]  Rd,
  input  logic [31:0] Write_data,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2
);

  logic [31:0] regs [32];
  logic        wr_en;

  // x0 is never written, so writes to index 0 are dropped here.
  assign wr_en = RegWrite && (Rd != 5'd0);

  // Reset wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[Rd] <= Write_data;
    end
  end

  // No write-to-read bypass: a same-cycle read of Rd sees the old value.
  // Index 0 is forced to zero so x0 never depends on array contents.
  assign read_data1 = (Rs1 == 5'd0) ? '0 : regs[Rs1];
  assign read_data2 = (Rs2 == 5'd0) ? '0 : regs[Rs2];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file.
// Expected read values come from a bench-side register model via a queue.

module tb_reg_file;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  Rs1;
  logic [4:0]  Rs2;
  logic [4:0]  Rd;
  logic [31:0] Write_data;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int checks;
  int errors;

  logic [31:0] model [32];
  logic [31:0] sb_q [$];

  reg_file dut (
    .clk        (clk),
    .reset      (reset),
    .RegWrite   (RegWrite),
    .Rs1        (Rs1),
    .Rs2        (Rs2),
    .Rd         (Rd),
    .Write_data (Write_data),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : model[a];
  endfunction

  // Drive read indices and push the expected outputs.
  task automatic rd_push(input logic [4:0] a, input logic [4:0] b);
    Rs1 = a;
    Rs2 = b;
    sb_q.push_back(mread(a));
    sb_q.push_back(mread(b));
  endtask

  // Let combinational outputs settle, then pop and compare.
  task automatic rd_pop(input string tag);
    logic [31:0] e1;
    logic [31:0] e2;
    #1;
    if (sb_q.size() < 2) begin
      chk({tag, "_sbq"}, 32'(sb_q.size()), 32'd2);
      sb_q.delete();
    end else begin
      e1 = sb_q.pop_front();
      e2 = sb_q.pop_front();
      chk({tag, "_rd1"}, read_data1, e1);
      chk({tag, "_rd2"}, read_data2, e2);
    end
  endtask

  task automatic rd(input string tag,
                    input logic [4:0] a,
                    input logic [4:0] b);
    rd_push(a, b);
    rd_pop(tag);
  endtask

  task automatic wr(input logic [4:0] a,
                    input logic [31:0] d,
                    input logic we);
    @(negedge clk);
    Rd = a;
    Write_data = d;
    RegWrite = we;
    @(posedge clk);
    #1;
    if (we && a != 5'd0) model[a] = d;
    RegWrite = 1'b0;
  endtask

  task automatic do_reset(input logic we,
                          input logic [4:0] a,
                          input logic [31:0] d);
    @(negedge clk);
    reset = 1'b1;
    RegWrite = we;
    Rd = a;
    Write_data = d;
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    reset = 1'b0;
    RegWrite = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    RegWrite = 1'b0;
    Rs1 = '0;
    Rs2 = '0;
    Rd = '0;
    Write_data = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'hx;

    // x0 reads zero even before any reset
    rd("pre_x0", 5'd0, 5'd0);

    do_reset(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rd("rst_sweep", 5'(i), 5'(31 - i));
    end

    // basic write/read, first write right after reset
    wr(5'd5, 32'hDEADBEEF, 1'b1);
    wr(5'd31, 32'h12345678, 1'b1);
    rd("basic", 5'd5, 5'd31);
    rd("same_idx", 5'd5, 5'd5);

    // x0 immutability
    wr(5'd0, 32'hFFFFFFFF, 1'b1);
    rd("x0", 5'd0, 5'd31);

    // write-enable gating
    wr(5'd7, 32'hA5A5A5A5, 1'b1);
    wr(5'd7, 32'h0, 1'b0);
    rd("we_gate", 5'd7, 5'd5);

    // no bypass: old value before edge, new value after
    wr(5'd3, 32'h1, 1'b1);
    @(negedge clk);
    Rd = 5'd3;
    Write_data = 32'h2;
    RegWrite = 1'b1;
    rd("nobyp_pre", 5'd3, 5'd3);
    @(posedge clk);
    #1;
    model[3] = 32'h2;
    RegWrite = 1'b0;
    rd("nobyp_post", 5'd3, 5'd0);

    // consecutive writes to all registers, then sweep
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), $urandom | 32'h1, 1'b1);
    end
    for (int i = 0; i < 32; i++) begin
      rd("fill", 5'(i), 5'($urandom_range(0, 31)));
    end

    // random write/read mix
    for (int i = 0; i < 40; i++) begin
      wr(5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
      rd("rand", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    // reset priority over a same-cycle write
    do_reset(1'b1, 5'd9, 32'h55);
    rd("rst_pri_x9", 5'd9, 5'd9);
    for (int i = 0; i < 32; i++) begin
      rd("rst2_sweep", 5'(i), 5'(i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
